fetch_unit: RTL and testbench

// - Parametrised instruction-fetch stage: owns the PC, drives instruction memory and queues fetched
//   {pc, instr} pairs in a prefetch FIFO feeding decode through a valid/ready handshake.
// - Replaces the single-register PC with stall, backpressure, a prefetch queue and flush-on-redirect.
// - Sits between instruction memory and the IF/ID boundary; execute drives redirects (taken branch).

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 84 ++++++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fetch_pkg                                                       |
// | Purpose: Shared types and defaults for the instruction-fetch stage.      |
// |          fetch_entry_t is one prefetch slot: {pc, instr}.                |
// | Ports  : none (package)                                                  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package fetch_pkg;

   localparam int unsigned FETCH_XLEN       = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int unsigned DEFAULT_PC_STEP  = 1;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] instr;
   } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fetch_fifo                                                      |
// | Purpose: Synchronous prefetch FIFO with push/pop/clear and occupancy.    |
// |          Head is presented combinationally and forced to zero when the   |
// |          FIFO is empty. Clear has priority over push and pop.            |
// | Ports  : i_clk, i_rst_n (async, active-low)                              |
// |          i_push/i_data  : write one entry (ignored when full)            |
// |          i_pop          : remove head (ignored when empty)               |
// |          i_clear        : drop every entry, reset pointers               |
// |          o_data/o_valid : head entry / head present                      |
// |          o_full/o_count : occupancy status                               |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = fetch_entry_t,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  T                 i_data,
   input  logic             i_pop,
   input  logic             i_clear,
   output T                 o_data,
   output logic             o_valid,
   output logic             o_full,
   output logic [CNT_W-1:0] o_count
);

   localparam int unsigned      c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] c_FULL  = CNT_W'(DEPTH);

   T                   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == c_FULL);
   assign w_empty = (r_count == '0);
   assign w_push  = i_push & ~w_full  & ~i_clear;
   assign w_pop   = i_pop  & ~w_empty & ~i_clear;

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked by occupancy.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = w_empty ? T'('0) : r_mem[r_rd_ptr];
   assign o_valid = ~w_empty;
   assign o_full  = w_full;
   assign o_count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fetch_unit                                                      |
// | Purpose: Instruction-fetch stage. Owns the PC, requests instruction      |
// |          memory, queues {pc, instr} pairs and hands them to decode over  |
// |          valid/ready. Redirect from execute flushes and reloads the PC.  |
// | Ports  : CLK, RST (async, active-low)                                    |
// |          inst_mem_*  : request/address out, data/valid in (same cycle)   |
// |          redirect_*  : taken branch/jump target from execute             |
// |          id_*        : head entry to decode, valid/ready handshake       |
// |          fifo_count_o: occupied prefetch entries                         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned      XLEN       = FETCH_XLEN,
   parameter int unsigned      PC_STEP    = DEFAULT_PC_STEP,
   parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(DEFAULT_RESET_PC),
   parameter int unsigned      FIFO_DEPTH = 4
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [XLEN-1:0]                 inst_mem_data_i,
   input  logic                            inst_mem_valid_i,
   output logic                            inst_mem_req_o,
   output logic [XLEN-1:0]                 inst_mem_address_o,
   input  logic                            redirect_i,
   input  logic [XLEN-1:0]                 redirect_pc_i,
   output logic                            id_valid_o,
   input  logic                            id_ready_i,
   output logic [XLEN-1:0]                 id_instr_o,
   output logic [XLEN-1:0]                 id_pc_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o
);

   localparam int unsigned     c_CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(PC_STEP);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   logic [XLEN-1:0]    r_pc;
   logic               w_full;
   logic               w_req;
   logic               w_push;
   logic               w_pop;
   logic               w_head_valid;
   entry_t             w_wr_entry;
   entry_t             w_head;
   logic [c_CNT_W-1:0] w_count;

   // Request depends only on reset, redirect and registered occupancy, so
   // decode's ready never reaches the memory request combinationally.
   assign w_req  = RST & ~redirect_i & ~w_full;
   assign w_push = w_req & inst_mem_valid_i;
   assign w_pop  = w_head_valid & id_ready_i;

   assign w_wr_entry = '{pc: r_pc, instr: inst_mem_data_i};

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_pc <= RESET_PC;
      end else if (redirect_i) begin
         r_pc <= redirect_pc_i;
      end else if (w_push) begin
         r_pc <= r_pc + c_PC_STEP;
      end
   end

   // Redirect drives the clear, which outranks the same-cycle push and pop.
   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (entry_t),
      .CNT_W (c_CNT_W)
   ) u_fifo (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_push  (w_push),
      .i_data  (w_wr_entry),
      .i_pop   (w_pop),
      .i_clear (redirect_i),
      .o_data  (w_head),
      .o_valid (w_head_valid),
      .o_full  (w_full),
      .o_count (w_count)
   );

   assign inst_mem_req_o     = w_req;
   assign inst_mem_address_o = r_pc;
   assign id_valid_o         = w_head_valid;
   assign id_instr_o         = w_head.instr;
   assign id_pc_o            = w_head.pc;
   assign fifo_count_o       = w_count;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_fetch_unit                                                   |
// | Purpose: Self-checking bench for fetch_unit. A per-cycle vector table    |
// |          with hand-derived address/occupancy, a negedge scoreboard that  |
// |          models the PC and prefetch queue, and hand-written sequences    |
// |          for redirect flush, PC wrap and mid-operation reset.            |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic            CLK;
   logic            RST;
   logic [XLEN-1:0] inst_mem_data_i;
   logic            inst_mem_valid_i;
   logic            inst_mem_req_o;
   logic [XLEN-1:0] inst_mem_address_o;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            id_valid_o;
   logic            id_ready_i;
   logic [XLEN-1:0] id_instr_o;
   logic [XLEN-1:0] id_pc_o;
   logic [CW-1:0]   fifo_count_o;

   fetch_unit #(
      .XLEN       (XLEN),
      .PC_STEP    (1),
      .RESET_PC   (32'h0),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .CLK                (CLK),
      .RST                (RST),
      .inst_mem_data_i    (inst_mem_data_i),
      .inst_mem_valid_i   (inst_mem_valid_i),
      .inst_mem_req_o     (inst_mem_req_o),
      .inst_mem_address_o (inst_mem_address_o),
      .redirect_i         (redirect_i),
      .redirect_pc_i      (redirect_pc_i),
      .id_valid_o         (id_valid_o),
      .id_ready_i         (id_ready_i),
      .id_instr_o         (id_instr_o),
      .id_pc_o            (id_pc_o),
      .fifo_count_o       (fifo_count_o)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Instruction memory contents: a fixed function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
   endfunction

   assign inst_mem_data_i = mem_word(inst_mem_address_o);

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mpc;
   logic        mon_en = 1'b0;

   always @(negedge CLK) begin
      if (mon_en && RST) begin
         logic exp_req;
         exp_req = !redirect_i && (q.size() != DEPTH);
         chk("mon_addr",  inst_mem_address_o, mpc);
         chk("mon_req",   32'(inst_mem_req_o), 32'(exp_req));
         chk("mon_count", 32'(fifo_count_o), 32'(q.size()));
         chk("mon_valid", 32'(id_valid_o), 32'(q.size() != 0));
         if (q.size() != 0) begin
            chk("mon_id_pc",    id_pc_o,    q[0].pc);
            chk("mon_id_instr", id_instr_o, q[0].instr);
         end else begin
            chk("mon_id_pc_zero",    id_pc_o,    32'h0);
            chk("mon_id_instr_zero", id_instr_o, 32'h0);
         end
         // Model the coming edge.
         if (redirect_i) begin
            q.delete();
            mpc = redirect_pc_i;
         end else begin
            if (q.size() != 0 && id_ready_i) void'(q.pop_front());
            if (exp_req && inst_mem_valid_i) begin
               q.push_back('{pc: mpc, instr: mem_word(mpc)});
               mpc = mpc + 32'd1;
            end
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic        v;
      logic        r;
      logic        rd;
      logic [31:0] rpc;
      logic [31:0] exp_addr;
      int          exp_cnt;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs[NV];

   task automatic drive(input logic v, input logic r, input logic rd, input logic [31:0] rpc);
      inst_mem_valid_i = v;
      id_ready_i       = r;
      redirect_i       = rd;
      redirect_pc_i    = rpc;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // Stream, fill to full, stall, drain, redirects (single and back-to-back).
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h0,  0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h1,  1};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h2,  1};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h3,  2};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h4,  3};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h5,  4};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h5,  4};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h5,  3};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h5,  3};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h5,  3};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h5,  2};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h40, 32'h6,  2};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h40, 0};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h80, 32'h41, 1};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h90, 32'h80, 0};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h90, 0};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h91, 1};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h92, 1};
      vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h92, 0};

      RST = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0);

      // Reset state
      #3;
      chk("rst_valid", 32'(id_valid_o), 32'h0);
      chk("rst_req",   32'(inst_mem_req_o), 32'h0);
      chk("rst_count", 32'(fifo_count_o), 32'h0);
      chk("rst_addr",  inst_mem_address_o, 32'h0);
      chk("rst_id_pc", id_pc_o, 32'h0);
      chk("rst_id_instr", id_instr_o, 32'h0);

      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      q.delete();
      mpc    = 32'h0;
      mon_en = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].v, vecs[i].r, vecs[i].rd, vecs[i].rpc);
         @(negedge CLK);
         chk($sformatf("tbl_addr[%0d]", i), inst_mem_address_o, vecs[i].exp_addr);
         chk($sformatf("tbl_cnt[%0d]", i), 32'(fifo_count_o), 32'(vecs[i].exp_cnt));
         next_cycle();
      end

      // Redirect while holding pc 5..7
      drive(1'b1, 1'b0, 1'b1, 32'h5);
      next_cycle();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      repeat (3) next_cycle();
      drive(1'b1, 1'b1, 1'b1, 32'h40);
      @(negedge CLK);
      chk("pre_redir_cnt", 32'(fifo_count_o), 32'd3);
      chk("pre_redir_head", id_pc_o, 32'h5);
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge CLK);
      chk("post_redir_cnt",   32'(fifo_count_o), 32'd0);
      chk("post_redir_valid", 32'(id_valid_o), 32'd0);
      chk("post_redir_addr",  inst_mem_address_o, 32'h40);
      next_cycle();

      // PC wrap at the top of the address space
      drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      next_cycle();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge CLK);
      chk("wrap_addr",  inst_mem_address_o, 32'h0);
      chk("wrap_id_pc", id_pc_o, 32'hFFFF_FFFF);
      chk("wrap_instr", id_instr_o, mem_word(32'hFFFF_FFFF));
      next_cycle();

      // Reset asserted mid-cycle with three entries queued
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      repeat (2) next_cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      chk("pre_rst_cnt", 32'(fifo_count_o), 32'd3);
      #2;
      mon_en = 1'b0;
      RST    = 1'b0;
      #1;
      chk("midrst_valid", 32'(id_valid_o), 32'h0);
      chk("midrst_count", 32'(fifo_count_o), 32'h0);
      chk("midrst_req",   32'(inst_mem_req_o), 32'h0);
      chk("midrst_id_pc", id_pc_o, 32'h0);
      chk("midrst_instr", id_instr_o, 32'h0);
      chk("midrst_addr",  inst_mem_address_o, 32'h0);
      repeat (2) next_cycle();
      RST = 1'b1;
      q.delete();
      mpc    = 32'h0;
      mon_en = 1'b1;
      @(negedge CLK);
      chk("post_rst_addr", inst_mem_address_o, 32'h0);
      next_cycle();

      // Restart streaming after reset
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      repeat (6) next_cycle();
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      repeat (3) next_cycle();
      mon_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_fetch_unit
`default_nettype wire
